// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory and hands pc/instruction to the IF/ID register as a
// single-cycle load strobe. Stalls park the returned word in a hold buffer;
// redirects discard in-flight data so decode never sees a stale instruction.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instruction
);

  localparam logic [31:0] Step = 32'(PC_STEP);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state;
  logic [31:0] pc_reg;
  logic        redirect_pending;
  logic [31:0] pending_pc;
  logic [31:0] hold_instr;

  logic [31:0] redirect_target;
  logic [31:0] pc_next;
  logic [31:0] restart_pc;

  // Word-aligned redirect target and sequential successor of the current PC
  always_comb begin
    redirect_target = {redirect_pc[31:2], 2'b00};
    pc_next         = pc_reg + Step;
    // A redirect arriving this cycle overrides one latched during the wait
    restart_pc      = redirect ? redirect_target : pending_pc;
  end

  // Fetch FSM with all outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= StIdle;
      pc_reg            <= RESET_PC;
      redirect_pending  <= 1'b0;
      pending_pc        <= 32'h0;
      hold_instr        <= NOP_INSTR;
      imem_req          <= 1'b0;
      imem_addr         <= RESET_PC;
      fetch_valid       <= 1'b0;
      fetch_pc          <= 32'h0;
      fetch_instruction <= NOP_INSTR;
    end else begin
      fetch_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          state    <= StReq;
          imem_req <= 1'b1;
          if (redirect) begin
            pc_reg            <= redirect_target;
            imem_addr         <= redirect_target;
            fetch_instruction <= NOP_INSTR;
          end else begin
            imem_addr <= pc_reg;
          end
        end
        StReq: begin
          if (!imem_ready) begin
            // Address must stay put while the memory is busy; remember the target
            if (redirect) begin
              redirect_pending  <= 1'b1;
              pending_pc        <= redirect_target;
              fetch_instruction <= NOP_INSTR;
            end
          end else if (redirect || redirect_pending) begin
            // Returned word belongs to the abandoned path: drop it
            pc_reg            <= restart_pc;
            imem_addr         <= restart_pc;
            redirect_pending  <= 1'b0;
            fetch_instruction <= NOP_INSTR;
          end else if (!stall) begin
            fetch_valid       <= 1'b1;
            fetch_pc          <= pc_reg;
            fetch_instruction <= imem_rdata;
            pc_reg            <= pc_next;
            imem_addr         <= pc_next;
          end else begin
            hold_instr <= imem_rdata;
            imem_req   <= 1'b0;
            state      <= StHold;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_reg            <= redirect_target;
            imem_addr         <= redirect_target;
            imem_req          <= 1'b1;
            fetch_instruction <= NOP_INSTR;
            state             <= StReq;
          end else if (!stall) begin
            // pc_reg still names the held word
            fetch_valid       <= 1'b1;
            fetch_pc          <= pc_reg;
            fetch_instruction <= hold_instr;
            pc_reg            <= pc_next;
            imem_addr         <= pc_next;
            imem_req          <= 1'b1;
            state             <= StReq;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic. A
// behavioural model predicts each delivery into a queue; a monitor pops and
// compares whenever the DUT strobes fetch_valid.
module tb_fetch_stage;

  localparam logic [31:0] Nop   = 32'h0000_0013;
  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instruction;

  logic [31:0] key  = 32'hA5A5_A5A5;
  logic [31:0] junk = 32'h0;

  // Memory returns a pure function of the address; garbage when not ready
  assign imem_rdata = imem_ready ? (imem_addr ^ key) : junk;

  fetch_stage dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_instruction (fetch_instruction)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } deliv_t;

  deliv_t exp_q[$];
  deliv_t mon_item;

  // Model: phase 0 = not started, 1 = requesting, 2 = holding a word
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic [31:0] m_held;
  bit          m_pend;
  bit          m_nop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = RstPc;
    m_tgt   = 32'h0;
    m_held  = 32'h0;
    m_pend  = 1'b0;
    m_nop   = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_delivery(input logic [31:0] pc, input logic [31:0] instr);
    deliv_t d;
    d.pc    = pc;
    d.instr = instr;
    exp_q.push_back(d);
  endtask

  // Drive one cycle of inputs, predict its effect, then check at the negedge
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    logic [31:0] tgt;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    junk        = $urandom;
    tgt         = rpc & 32'hFFFF_FFFC;
    case (m_phase)
      0: begin
        if (rd) begin
          m_pc  = tgt;
          m_nop = 1'b1;
        end
        m_phase = 1;
      end
      1: begin
        if (!rdy) begin
          if (rd) begin
            m_pend = 1'b1;
            m_tgt  = tgt;
            m_nop  = 1'b1;
          end
        end else if (rd || m_pend) begin
          m_pc   = rd ? tgt : m_tgt;
          m_pend = 1'b0;
          m_nop  = 1'b1;
        end else if (!st) begin
          push_delivery(m_pc, mem_word(m_pc));
          m_pc  = m_pc + 32'd4;
          m_nop = 1'b0;
        end else begin
          m_held  = mem_word(m_pc);
          m_phase = 2;
        end
      end
      default: begin
        if (rd) begin
          m_pc    = tgt;
          m_nop   = 1'b1;
          m_phase = 1;
        end else if (!st) begin
          push_delivery(m_pc, m_held);
          m_pc    = m_pc + 32'd4;
          m_nop   = 1'b0;
          m_phase = 1;
        end
      end
    endcase
    @(negedge clock);
    chk("imem_req", 32'(imem_req), 32'(m_phase == 1));
    if (m_phase == 1) chk("imem_addr", imem_addr, m_pc);
    if (m_nop) chk("nop_after_redirect", fetch_instruction, Nop);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_addr"}, imem_addr, RstPc);
    chk({tag, "_valid"}, 32'(fetch_valid), 32'h0);
    chk({tag, "_instr"}, fetch_instruction, Nop);
  endtask

  // Hold reset for three cycles, then release on a negedge
  task automatic do_reset();
    reset      = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      check_reset_outputs("reset");
      chk("reset_fetch_pc", fetch_pc, 32'h0);
    end
    reset = 1'b1;
  endtask

  // Monitor: every strobe must match the oldest predicted delivery
  initial begin
    forever begin
      @(negedge clock);
      if (reset && fetch_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc %h expected none at %0t", fetch_pc, $time);
        end else begin
          mon_item = exp_q.pop_front();
          chk("fetch_pc", fetch_pc, mon_item.pc);
          chk("fetch_instruction", fetch_instruction, mon_item.instr);
        end
      end
    end
  end

  initial begin
    // Zero-wait fetch straight out of reset
    do_reset();
    cycle(0, 0, 32'h0, 1);
    repeat (8) cycle(0, 0, 32'h0, 1);

    // Ready every third cycle
    do_reset();
    cycle(0, 0, 32'h0, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 32'h0, (i % 3) == 2);

    // Stall arriving with ready at pc 0x8
    do_reset();
    cycle(0, 0, 32'h0, 0);
    repeat (2) cycle(0, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 1);
    repeat (3) cycle(1, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);
    repeat (2) cycle(0, 0, 32'h0, 1);

    // Redirect while the request at 0x10 is waiting
    do_reset();
    cycle(0, 0, 32'h0, 0);
    repeat (4) cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 1, 32'h0000_0203, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    repeat (2) cycle(0, 0, 32'h0, 1);

    // Redirect coinciding with stall release in hold
    do_reset();
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 0);
    cycle(0, 1, 32'h0000_0040, 0);
    cycle(0, 0, 32'h0, 0);
    repeat (2) cycle(0, 0, 32'h0, 1);

    // PC wrap, then asynchronous reset in the middle of a cycle
    do_reset();
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    repeat (3) cycle(0, 0, 32'h0, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    do_reset();
    cycle(0, 0, 32'h0, 1);
    repeat (3) cycle(0, 0, 32'h0, 1);

    // Random traffic
    key = $urandom;
    do_reset();
    cycle(0, 0, 32'h0, 0);
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom,
            $urandom_range(0, 1) == 1);
    end
    repeat (3) cycle(0, 0, 32'h0, 0);
    #1;
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch producer for the IF/ID pipeline register.
- Owns the PC, issues requests to a variable-latency instruction memory (req/ready handshake), and presents pc/instruction with a one-cycle load strobe to IF/ID.
- Handles pipeline stalls from the hazard unit and redirects from branch/jump resolution, so a stale instruction is never handed to decode.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, increment applied after each delivered instruction.
- NOP_INSTR, 32'h00000013, value driven on fetch_instruction when nothing valid is held (addi x0,x0,0).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  downstream stall; IF/ID must not be loaded while high.
- redirect  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  instruction memory address.
- imem_ready  input  1  memory data valid this cycle; meaningful only while imem_req=1.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- fetch_valid  output  1  load strobe to IF/ID, one cycle per delivered instruction.
- fetch_pc  output  32  PC of the delivered instruction.
- fetch_instruction  output  32  delivered instruction word.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_reg=RESET_PC, state=IDLE, redirect_pending=0.
  - imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_pc=0, fetch_instruction=NOP_INSTR.
  - Outputs change immediately, without waiting for a clock edge.
  - Reset asserted mid-request aborts the request; imem_rdata is ignored until req is reissued.
- All outputs are registered (Moore). IF/ID samples on the falling edge, so each fetch_valid pulse spans a full cycle and is stable at the negedge.
- States: IDLE, REQ, HOLD.
- IDLE: first rising edge after reset release -> REQ.
- REQ:
  - imem_req=1, imem_addr=pc_reg.
  - imem_addr must not change while imem_req=1 and imem_ready=0.
  - redirect=1 with imem_ready=0: latch redirect_pc into pending target, set redirect_pending=1, keep the current address.
  - imem_ready=1 with redirect=1, or with redirect_pending=1: discard imem_rdata. Set pc_reg to the target; a current redirect takes precedence over a pending one. Clear pending, stay REQ, fetch_valid=0. The new address appears on imem_addr the next cycle.
  - imem_ready=1, no redirect, stall=0: next cycle fetch_valid=1, fetch_pc=pc_reg, fetch_instruction=imem_rdata. Then pc_reg+=PC_STEP, stay REQ. Back-to-back ready gives one instruction per cycle.
  - imem_ready=1, no redirect, stall=1: capture pc/rdata into the hold buffer -> HOLD, fetch_valid=0.
  - stall with imem_ready=0: no effect.
- HOLD:
  - imem_req=0, fetch_valid=0.
  - fetch_pc/fetch_instruction keep their last delivered values.
  - redirect=1: drop the held word, pc_reg=redirect_pc -> REQ. Redirect takes priority over stall release in the same cycle.
  - stall=0, no redirect: next cycle fetch_valid=1 with the held pc/instruction, pc_reg+=PC_STEP -> REQ.
  - stall=1: remain in HOLD.
- fetch_valid is never high for two cycles carrying the same pc, except when a redirect targets that same pc.
- After any redirect, fetch_instruction=NOP_INSTR until the next delivery.
- Arithmetic: pc_reg is 32-bit unsigned and wraps, so 32'hFFFFFFFC + 4 = 32'h00000000. The redirect target is {redirect_pc[31:2],2'b00}.

Test Plan:
- Reset/zero-wait fetch: reset low 3 cycles, then high; imem_ready tied 1, rdata=addr^32'hA5A5A5A5. Expect: imem_addr 0,4,8,… one per cycle; fetch_valid continuously high from the 2nd cycle after REQ; each fetch_pc matches its rdata.
- Wait states: imem_ready high every 3rd cycle. Expect: imem_addr stable during the wait cycles; exactly one fetch_valid per ready; pc sequence 0,4,8 with no gaps or duplicates.
- Stall/hold: stall=1 for 4 cycles arriving with ready at pc=0x8. Expect: no fetch_valid and imem_req=0 during the stall; on release, one fetch_valid with pc=0x8 and the held word, then requests resume at 0xC.
- Redirect during wait: request at 0x10 pending, redirect=1 with redirect_pc=0x203. Expect: imem_addr stays 0x10 until ready; that data is discarded (no fetch_valid); next imem_addr=0x200; next delivered fetch_pc=0x200.
- Simultaneous redirect and stall release in HOLD (redirect_pc=0x40). Expect: held word dropped; next delivery pc=0x40; fetch_instruction=0x00000013 in between.
- Wrap and async reset: redirect to 0xFFFFFFFC, ready=1. Expect: delivered pcs 0xFFFFFFFC then 0x00000000. Then assert reset mid-cycle; expect imem_req=0 and fetch_valid=0 before the next clock edge, and fetch restarting at RESET_PC.
